// File: rtl/matmul_mac_sequencer.sv
// Schedules one shared MAC datapath through a 4x4 matrix multiply, add or subtract,
// driving operand selects, accumulator control and delayed result write-back strobes.
module matmul_mac_sequencer #(
  parameter int N       = 4,
  parameter int IDX_W   = $clog2(N),
  parameter int MAC_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic               hold,
  output logic               issue,
  output logic [IDX_W-1:0]   a_row,
  output logic [IDX_W-1:0]   a_col,
  output logic [IDX_W-1:0]   b_row,
  output logic [IDX_W-1:0]   b_col,
  output logic               acc_clr,
  output logic               sub,
  output logic               wb_en,
  output logic [2*IDX_W-1:0] wb_idx,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [2:0]         state_dbg
);

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [IDX_W-1:0] MAX_IDX   = IDX_W'(N - 1);
  localparam logic [DW-1:0]    DRAIN_END = DW'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            op_q;
  logic [IDX_W-1:0]      i_cnt, j_cnt, k_cnt;
  logic [DW-1:0]         drain_cnt;
  logic [MAC_LAT-1:0]    wb_v;
  logic [2*IDX_W-1:0]    wb_i [MAC_LAT];
  logic                  mul_mode, accept, elem_done, last_issue;

  // Handshake: issue is a valid-only strobe (the MAC always accepts); hold is the
  // sole backpressure and only gates new issues, never the write-back pipeline.
  always_comb begin
    mul_mode   = (op_q == 2'b00);
    accept     = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    issue      = (state == S_ISSUE) && !hold;
    elem_done  = !mul_mode || (k_cnt == MAX_IDX);
    last_issue = issue && elem_done && (i_cnt == MAX_IDX) && (j_cnt == MAX_IDX);
    state_nxt  = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = (op == 2'b01) ? S_ERR : S_ISSUE;
      S_ISSUE:               if (last_issue) state_nxt = S_DRAIN;
      S_DRAIN:               if (drain_cnt == DRAIN_END) state_nxt = S_DONE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      op_q      <= 2'b00;
      i_cnt     <= '0;
      j_cnt     <= '0;
      k_cnt     <= '0;
      drain_cnt <= '0;
      wb_v      <= '0;
      for (int s = 0; s < MAC_LAT; s++) wb_i[s] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q  <= op;
        i_cnt <= '0;
        j_cnt <= '0;
        k_cnt <= '0;
      end else if (issue) begin
        if (!elem_done) begin
          k_cnt <= k_cnt + 1'b1;
        end else begin
          k_cnt <= '0;
          if (j_cnt == MAX_IDX) begin
            j_cnt <= '0;
            i_cnt <= (i_cnt == MAX_IDX) ? '0 : i_cnt + 1'b1;
          end else begin
            j_cnt <= j_cnt + 1'b1;
          end
        end
      end
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
      // With N a power of two, {i,j} is exactly i*N+j.
      wb_v[0] <= issue && elem_done;
      wb_i[0] <= {i_cnt, j_cnt};
      for (int s = 1; s < MAC_LAT; s++) begin
        wb_v[s] <= wb_v[s-1];
        wb_i[s] <= wb_i[s-1];
      end
    end
  end

  assign a_row     = i_cnt;
  assign a_col     = mul_mode ? k_cnt : j_cnt;
  assign b_row     = mul_mode ? k_cnt : i_cnt;
  assign b_col     = j_cnt;
  assign acc_clr   = issue && (!mul_mode || k_cnt == '0);
  assign sub       = (state == S_ISSUE) && (op_q == 2'b11);
  assign wb_en     = wb_v[MAC_LAT-1];
  assign wb_idx    = wb_i[MAC_LAT-1];
  assign busy      = (state == S_ISSUE) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);
  assign state_dbg = state;

endmodule

// File: tb/tb_matmul_mac_sequencer.sv
// Scoreboard bench: the driver derives expected issues, write-backs and status from
// matrix index arithmetic; a negedge monitor pops and compares against the DUT.
module tb_matmul_mac_sequencer;
  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int LAT = 2;
  localparam int ISS_W = 32 + 4*IW + 2;
  localparam int WB_W  = 32 + 2*IW;
  localparam int ST_W  = 32 + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic          hold = 1'b0;
  logic          issue, acc_clr, sub, wb_en, busy, done, error;
  logic [IW-1:0] a_row, a_col, b_row, b_col;
  logic [2*IW-1:0] wb_idx;
  logic [2:0]    state_dbg;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic fin = 1'b0;

  logic [ISS_W-1:0] iss_q[$];
  logic [WB_W-1:0]  wb_q[$];
  logic [ST_W-1:0]  st_q[$];

  matmul_mac_sequencer #(.N(N), .IDX_W(IW), .MAC_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .hold(hold),
    .issue(issue), .a_row(a_row), .a_col(a_col), .b_row(b_row), .b_col(b_col),
    .acc_clr(acc_clr), .sub(sub), .wb_en(wb_en), .wb_idx(wb_idx),
    .busy(busy), .done(done), .error(error), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [ISS_W-1:0] got_i, exp_i;
    logic [WB_W-1:0]  got_w, exp_w;
    logic [ST_W-1:0]  exp_s;
    logic [2:0]       got_s;
    logic [27:0]      all_out;
    if (issue === 1'b1) begin
      got_i = {32'(cyc), a_row, a_col, b_row, b_col, acc_clr, sub};
      checks++;
      if (iss_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: cycle %0d got %h, expected none", cyc, got_i);
      end else begin
        exp_i = iss_q.pop_front();
        if (got_i !== exp_i) begin
          errors++;
          $display("FAIL issue_fields: got %h, expected %h", got_i, exp_i);
        end
      end
    end else if (iss_q.size() > 0 && int'(iss_q[0][ISS_W-1 -: 32]) <= cyc) begin
      checks++; errors++;
      exp_i = iss_q.pop_front();
      $display("FAIL issue_missing: cycle %0d got issue=%b, expected %h", cyc, issue, exp_i);
    end
    if (wb_en === 1'b1) begin
      got_w = {32'(cyc), wb_idx};
      checks++;
      if (wb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: cycle %0d got idx %0d, expected none", cyc, wb_idx);
      end else begin
        exp_w = wb_q.pop_front();
        if (got_w !== exp_w) begin
          errors++;
          $display("FAIL wb_fields: got %h, expected %h", got_w, exp_w);
        end
      end
    end else if (wb_q.size() > 0 && int'(wb_q[0][WB_W-1 -: 32]) <= cyc) begin
      checks++; errors++;
      exp_w = wb_q.pop_front();
      $display("FAIL wb_missing: cycle %0d got wb_en=%b, expected %h", cyc, wb_en, exp_w);
    end
    while (st_q.size() > 0 && int'(st_q[0][ST_W-1 -: 32]) <= cyc) begin
      exp_s = st_q.pop_front();
      checks++;
      if (exp_s[3]) begin
        all_out = {issue, a_row, a_col, b_row, b_col, acc_clr, sub, wb_en, wb_idx,
                   busy, done, error, 8'h00};
        if (all_out !== '0) begin
          errors++;
          $display("FAIL reset_outputs: cycle %0d got %h, expected 0", cyc, all_out);
        end
      end else begin
        got_s = {busy, done, error};
        if (got_s !== exp_s[2:0]) begin
          errors++;
          $display("FAIL status: cycle %0d got busy/done/error %b, expected %b",
                   cyc, got_s, exp_s[2:0]);
        end
      end
    end
    if (fin) begin
      checks++;
      if (iss_q.size() + wb_q.size() + st_q.size() != 0) begin
        errors++;
        $display("FAIL queues_drained: got %0d/%0d/%0d left, expected 0/0/0",
                 iss_q.size(), wb_q.size(), st_q.size());
      end
      fin = 1'b0;
    end
  end

  // driver tasks
  task automatic push_st(input int c, input logic all0, input logic b, input logic d,
                         input logic e);
    st_q.push_back({32'(c), all0, b, d, e});
  endtask

  task automatic run_op(input logic [1:0] o, input int hold_lo, input int hold_hi,
                        input int hold_pct, input int abort_at, input int poke_at);
    int r, t, n_iss, ii, jj, kk;
    logic h, mul;
    @(posedge clk); #1;
    start = 1'b1; op = o; hold = 1'b0;
    if (o == 2'b01) begin
      repeat (4) begin
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom_range(0, 3));
        push_st(cyc, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      return;
    end
    mul = (o == 2'b00);
    n_iss = mul ? N*N*N : N*N;
    t = 0; r = 0;
    while (t < n_iss) begin
      @(posedge clk); #1;
      r++;
      start = (r == poke_at);
      op = (r == poke_at) ? 2'b01 : 2'($urandom_range(0, 3));
      h = (r >= hold_lo && r <= hold_hi) || (int'($urandom_range(0, 99)) < hold_pct);
      hold = h;
      push_st(cyc, 1'b0, 1'b1, 1'b0, 1'b0);
      if (!h) begin
        if (mul) begin
          ii = t / (N*N); jj = (t / N) % N; kk = t % N;
          iss_q.push_back({32'(cyc), IW'(ii), IW'(kk), IW'(kk), IW'(jj), kk == 0, 1'b0});
        end else begin
          ii = t / N; jj = t % N; kk = N - 1;
          iss_q.push_back({32'(cyc), IW'(ii), IW'(jj), IW'(ii), IW'(jj), 1'b1, o[0]});
        end
        if (kk == N - 1) wb_q.push_back({32'(cyc + LAT), (2*IW)'(ii*N + jj)});
        t++;
      end
      if (r == abort_at) begin
        rst = 1'b0;
        for (int q = wb_q.size() - 1; q >= 0; q--)
          if (int'(wb_q[q][WB_W-1 -: 32]) > cyc) wb_q.delete(q);
        @(posedge clk); #1;
        rst = 1'b1; hold = 1'b0; start = 1'b0;
        push_st(cyc, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (LAT + 2) begin
          @(posedge clk); #1;
          push_st(cyc, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        return;
      end
    end
    repeat (LAT) begin
      @(posedge clk); #1;
      start = 1'b0; hold = 1'($urandom_range(0, 1));
      push_st(cyc, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    hold = 1'b0;
    push_st(cyc, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [1:0] ops [4];
    ops[0] = 2'b00; ops[1] = 2'b10; ops[2] = 2'b11; ops[3] = 2'b01;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_st(cyc, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_op(2'b00, -1, -1, 0, -1, -1);   // plain multiply
    run_op(2'b11, -1, -1, 0, -1, -1);   // subtract
    run_op(2'b01, -1, -1, 0, -1, -1);   // illegal op
    run_op(2'b10, -1, -1, 0, -1, -1);   // add clears error
    run_op(2'b00, 10, 14, 0, -1, -1);   // hold window
    run_op(2'b00, -1, -1, 0, 20, -1);   // reset mid-operation
    run_op(2'b00, -1, -1, 0, -1, -1);   // clean restart after reset
    run_op(2'b10, 5, 24, 0, -1, 30);    // start while busy ignored
    for (int n = 0; n < 8; n++)
      run_op(ops[$urandom_range(0, 3)], -1, -1, 20, -1, -1);
    repeat (LAT + 2) @(posedge clk);
    #1;
    fin = 1'b1;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_mac_sequencer.md
Name: matmul_mac_sequencer

Overview:
- Sequences a single shared 2-bit multiply-accumulate (MAC) datapath to compute the 4x4 matrix product, sum or difference of the A and B operand registers.
- Generates operand-element selects, accumulator control and result write-back strobes for the 16-entry, 6-bit result register file.
- Sits between the top-level calculator FSM, which pulses start once all operands are entered, and the MAC/result datapath.
- Replaces the per-operation Add_Path/Multiply_Path internal counters with one shared schedule.

Parameters:
- N, 4, matrix dimension (power of 2, 2..8).
- IDX_W, $clog2(N), width of one row/column index.
- MAC_LAT, 2, cycles from an operand issue to the accumulator result being valid (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse; begins an operation.
- op  in  2  operation, sampled on start: 00 multiply, 10 add, 11 subtract, 01 illegal.
- hold  in  1  1 = suspend operand issue; the write-back pipeline keeps advancing.
- issue  out  1  operand pair valid this cycle.
- a_row, a_col  out  IDX_W each  element select into A.
- b_row, b_col  out  IDX_W each  element select into B.
- acc_clr  out  1  accumulator loads the product/sum instead of accumulating; qualified by issue.
- sub  out  1  MAC computes A-B instead of A+B (add mode only).
- wb_en  out  1  write accumulator into the result file.
- wb_idx  out  2*IDX_W  result element index, i*N+j.
- busy  out  1  operation in progress.
- done  out  1  operation complete; sticky.
- error  out  1  illegal op; sticky.

Behaviour:
- Reset (rst=0 on a clock edge):
  - state goes to IDLE; all outputs 0; i/j/k counters and the write-back pipeline are flushed.
  - This applies mid-operation too: no wb_en may appear after reset.
- States: IDLE, ISSUE, DRAIN, DONE, ERR.
- IDLE/DONE/ERR with start=1:
  - op is latched.
  - op=01 -> ERR (error=1 next cycle, done=0).
  - Otherwise -> ISSUE with counters cleared, done=0, error=0, busy=1 next cycle.
- start while busy is ignored.
- ISSUE, multiply (hold=0):
  - One issue per cycle in i-major, then j, then k order (k fastest).
  - a=(i,k), b=(k,j); acc_clr=1 when k=0; sub=0.
  - N^3 issues total.
- ISSUE, add/sub (hold=0):
  - One issue per element, i-major then j; a=b=(i,j).
  - acc_clr=1 on every issue; sub=op[0].
  - N^2 issues total.
- hold=1 in ISSUE: issue=0, counters frozen; select outputs keep their last values.
- Write-back pipeline (MAC_LAT stages of {valid, idx}):
  - An issue that completes an element (k=N-1 for multiply, every issue for add/sub) produces wb_en=1 exactly MAC_LAT cycles later, with wb_idx of that element.
  - The pipeline is never stalled by hold.
- After the final issue: ISSUE -> DRAIN. DRAIN counts MAC_LAT cycles, then -> DONE.
- DONE: busy=0, done=1, held until the next accepted start or reset.
- busy=1 exactly in ISSUE and DRAIN.
- Width rules:
  - wb_idx = i*N+j, zero-extended, no overflow.
  - Counters wrap only at the end of an operation; k wraps N-1->0 with j increment, j wraps with i increment.

Test Plan:
- Reset then multiply: rst=0 for 2 cycles, start at cycle 0 with op=00, hold=0, N=4, MAC_LAT=2.
  -> issue=1 on cycles 1..64; first issue a=(0,0), b=(0,0), acc_clr=1; cycle 4 a=(0,3), b=(3,0).
  -> wb_en on cycles 6, 10, ..., 66 with wb_idx 0..15; busy=0 and done=1 at cycle 67.
- Subtract: start with op=11 at cycle 0.
  -> issue with sub=1 and acc_clr=1 on cycles 1..16; wb_en on cycles 3..18 with wb_idx 0..15; done=1 at cycle 19.
- Illegal op: start with op=01.
  -> error=1 from cycle 1, issue never asserts, done=0.
  -> A later start with op=10 clears error and runs the add normally.
- Hold: during multiply, hold=1 on cycles 10..14.
  -> no issue on those cycles; the issue sequence resumes at the frozen (i,j,k).
  -> Any wb_en due in that window still fires; completion is delayed by 5 cycles (done at cycle 72).
- Reset mid-operation: rst=0 at cycle 20 of a multiply.
  -> next cycle all outputs 0, no further wb_en.
  -> A start after reset release begins at element 0 with a clean schedule.
- start while busy: pulse start with op=01 at cycle 30 of an add.
  -> ignored; error stays 0 and the add completes normally.
